// File: rtl/axi_pkg.sv
// Shared AXI read/write responder definitions: burst, response and size codes,
// plus the responder state encoding.
package axi_pkg;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] SIZE_4B     = 3'b010;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } rd_state_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI3 next-beat address for 4-byte beats; an illegal WRAP length
// falls back to INCR addressing and is reported through wrap_illegal.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        burst,
   input  logic [3:0]        len,
   output logic [ADDR_W-1:0] nxt,
   output logic              wrap_illegal
);
   logic [ADDR_W-1:0] inc;
   logic [ADDR_W-1:0] mask;
   logic              wrap_ok;

   always_comb begin
      inc          = addr + ADDR_W'(4);
      // Wrap window is (len+1) beats of 4 bytes.
      mask         = ADDR_W'({len, 2'b11});
      wrap_ok      = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      wrap_illegal = (burst == BURST_WRAP) && !wrap_ok;
      case (burst)
         BURST_FIXED: nxt = addr;
         BURST_WRAP:  nxt = wrap_ok ? ((addr & ~mask) | (inc & mask)) : inc;
         default:     nxt = inc;
      endcase
   end
endmodule

// File: rtl/axi_rd_responder.sv
// AXI3 read-channel slave backed by a word-addressed ROM, one outstanding burst.
// Define AXI_RD_RESPONDER_STALL_EN to insert LFSR-driven gaps on the R channel.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1FC0_0000,
  parameter                    INIT_FILE = ""
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [3:0]        arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);
  logic [DATA_W-1:0] mem [2**MEM_AW];

  initial begin
    for (int i = 0; i < 2**MEM_AW; i++) mem[i] = '0;
  end

  rd_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        cnt, len;
  logic [1:0]        burst;
  logic [2:0]        size;

  logic [ADDR_W-1:0] nxt;
  logic              wrap_illegal;
  logic [1:0]        sel_burst;
  logic [3:0]        sel_len;
  logic [2:0]        sel_size;
  logic [ADDR_W-3:0] bword;
  logic              in_range, beat_ok, hs, show;
  logic [DATA_W-1:0] beat_data;
  logic [1:0]        beat_resp;

  // In IDLE the burst attributes come straight off AR so the first beat can be read
  // in the handshake cycle; in SEND they come from the latched copy.
  assign sel_burst = (state == IDLE) ? arburst : burst;
  assign sel_len   = (state == IDLE) ? arlen   : len;
  assign sel_size  = (state == IDLE) ? arsize  : size;
  assign bword     = (state == IDLE) ? araddr[ADDR_W-1:2] : nxt[ADDR_W-1:2];

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr        (addr),
    .burst       (sel_burst),
    .len         (sel_len),
    .nxt         (nxt),
    .wrap_illegal(wrap_illegal)
  );

  assign in_range  = bword[ADDR_W-3:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW+2];
  assign beat_ok   = in_range && (sel_size == SIZE_4B) && (sel_burst != 2'b11) && !wrap_illegal;
  assign beat_data = beat_ok ? mem[bword[MEM_AW-1:0]] : '0;
  assign beat_resp = beat_ok ? RESP_OKAY : RESP_SLVERR;
  assign hs        = rvalid && rready;

`ifdef AXI_RD_RESPONDER_STALL_EN
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // rvalid is registered, so gate it on the value the LFSR will hold next cycle.
  assign show     = lfsr_nxt[1:0] != 2'b00;

  always_ff @(posedge aclk) begin
    if (areset) lfsr <= 16'hACE1;
    else        lfsr <= lfsr_nxt;
  end
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
      addr    <= '0;
      cnt     <= '0;
      len     <= '0;
      burst   <= '0;
      size    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arready && arvalid) begin
            state   <= SEND;
            arready <= 1'b0;
            rid     <= arid;
            len     <= arlen;
            burst   <= arburst;
            size    <= arsize;
            addr    <= araddr;
            cnt     <= '0;
            rvalid  <= show;
            rlast   <= (arlen == 4'd0);
            rdata   <= beat_data;
            rresp   <= beat_resp;
          end else begin
            arready <= 1'b1;
          end
        end
        SEND: begin
          if (hs && rlast) begin
            state   <= IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
          end else begin
            // A beat is always pending in SEND; only a handshake advances it.
            rvalid <= show;
            if (hs) begin
              addr  <= nxt;
              cnt   <= cnt + 4'd1;
              rlast <= (cnt + 4'd1 == len);
              rdata <= beat_data;
              rresp <= beat_resp;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: directed and random AR bursts, expected beats
// queued from a word-level model, compared by an independent R-channel monitor.
module tb_axi_rd_responder;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [3:0]  arlen = '0;
   logic [2:0]  arsize = 3'b010;
   logic [1:0]  arburst = 2'b01;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b1;

   always #5 aclk = ~aclk;

   axi_rd_responder dut (
      .aclk(aclk), .areset(areset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       e;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] model_mem [1024];
   int          rr_mode = 0;
   int          pidx = 0;
   logic        pat [10] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
   logic        prev_stall = 1'b0;
   logic [38:0] prev_beat = '0;
   logic        chk_ar_next = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected beats from the AXI rules, in word units.
   task automatic push_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] l,
                             input logic [2:0] sz, input logic [1:0] b);
      int          n;
      bit          err, wrap_ok;
      logic [29:0] w0, wb, w;
      beat_t       x;
      n       = int'(l) + 1;
      w0      = a[31:2];
      wrap_ok = (n == 2) || (n == 4) || (n == 8) || (n == 16);
      err     = (sz != 3'b010) || (b == 2'b11) || (b == 2'b10 && !wrap_ok);
      wb      = w0 - (w0 % 30'(n));
      for (int i = 0; i < n; i++) begin
         if (b == 2'b00)                w = w0;
         else if (b == 2'b10 && wrap_ok) w = wb + ((w0 - wb + 30'(i)) % 30'(n));
         else                           w = w0 + 30'(i);
         x.id = id;
         x.last = (i == n - 1);
         if (!err && w[29:10] == 20'h1FC00) begin
            x.data = model_mem[w[9:0]];
            x.resp = 2'b00;
         end else begin
            x.data = 32'h0;
            x.resp = 2'b10;
         end
         exp_q.push_back(x);
      end
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] l,
                        input logic [2:0] sz, input logic [1:0] b);
      int t = 0;
      @(negedge aclk);
      while (!arready && t < 200) begin
         @(negedge aclk);
         t++;
      end
      check("arready_wait", arready, 1);
      arid = id; araddr = a; arlen = l; arsize = sz; arburst = b; arvalid = 1'b1;
      push_burst(id, a, l, sz, b);
      @(posedge aclk);
      #1 arvalid = 1'b0;
      @(negedge aclk);
      check("r_latency", rvalid, 1);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge aclk);
         t++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   always @(posedge aclk) begin
      #1;
      case (rr_mode)
         1: rready = ($urandom_range(0, 9) < 6);
         2: if (rvalid) begin
               rready = (pidx < 10) ? pat[pidx] : 1'b1;
               pidx++;
            end
         default: rready = 1'b1;
      endcase
   end

   // Monitor: pops one expected beat per R handshake, checks hold under backpressure.
   always @(negedge aclk) begin
      if (!areset) begin
         if (chk_ar_next) begin
            check("arready_after_last", arready, 1);
            chk_ar_next = 1'b0;
         end
         if (prev_stall && rvalid) check("hold_stable", {rid, rdata, rresp, rlast}, prev_beat);
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("rid", rid, e.id);
               check("rdata", rdata, e.data);
               check("rresp", rresp, e.resp);
               check("rlast", rlast, e.last);
               if (rlast) chk_ar_next = 1'b1;
            end
         end
         prev_stall = rvalid && !rready;
         prev_beat  = {rid, rdata, rresp, rlast};
      end
   end

   initial begin
      repeat (30000) @(posedge aclk);
      $display("FAIL watchdog: run did not complete within 30000 cycles");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      logic [31:0] a;
      arvalid = 1'b1;
      araddr  = 32'h1FC0_0000;
      #1;
      for (int k = 0; k < 1024; k++) begin
         model_mem[k] = 32'h1000_0000 + k;
         dut.mem[k]   = model_mem[k];
      end
      repeat (3) begin
         @(negedge aclk);
         check("rst_arready", arready, 0);
         check("rst_rvalid", rvalid, 0);
      end
      areset = 1'b0;
      @(negedge aclk);
      check("post_rst_arready", arready, 1);
      check("post_rst_rvalid", rvalid, 0);
      arvalid = 1'b0;
      @(negedge aclk);
      check("no_accept_in_rst", rvalid, 0);

      do_ar(4'd3, 32'h1FC0_0020, 4'd7, 3'b010, 2'b01);  drain();
      do_ar(4'd5, 32'h1FC0_0004, 4'd0, 3'b010, 2'b01);  drain();
      do_ar(4'd1, 32'h1FC0_0008, 4'd3, 3'b010, 2'b10);  drain();
      rr_mode = 2; pidx = 0;
      do_ar(4'd7, 32'h1FC0_0040, 4'd7, 3'b010, 2'b01);  drain();
      rr_mode = 0;
      do_ar(4'd2, 32'h0000_1000, 4'd1, 3'b010, 2'b01);  drain();
      do_ar(4'd4, 32'h1FC0_0FFC, 4'd1, 3'b010, 2'b01);  drain();
      do_ar(4'd6, 32'h1FC0_0100, 4'd3, 3'b001, 2'b01);  drain();
      do_ar(4'd8, 32'h1FC0_0010, 4'd2, 3'b010, 2'b10);  drain();
      do_ar(4'd9, 32'h1FC0_0030, 4'd3, 3'b010, 2'b00);  drain();
      do_ar(4'hA, 32'h1FC0_0204, 4'd2, 3'b010, 2'b11);  drain();
      do_ar(4'hB, 32'h1FC0_03C8, 4'd15, 3'b010, 2'b10); drain();

      rr_mode = 1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0:       a = $urandom();
            1:       a = 32'h1FC0_0FC0 + ($urandom_range(0, 15) << 2);
            default: a = 32'h1FC0_0000 + $urandom_range(0, 4095);
         endcase
         do_ar(4'($urandom_range(0, 15)), a, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010,
               2'($urandom_range(0, 3)));
      end
      drain();
      rr_mode = 0;
      repeat (2) @(negedge aclk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
